// File: rtl/uart_seg7_scan_ctrl.sv
// Two-digit multiplexed 7-segment scheduler for bytes from a UART receiver.
// New bytes are swapped in only at frame start; "--" shows when no byte is valid.
module uart_seg7_scan_ctrl #(
  parameter int CLKS_PER_DIGIT = 12500,
  parameter int BLANK_CLKS     = 250,
  parameter int TIMEOUT_CLKS   = 250000000,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [6:0] o_Seg,
  output logic       o_Dig1,
  output logic       o_Dig2,
  output logic       o_Frame_Tick,
  output logic [7:0] o_Shown_Byte,
  output logic       o_Shown_Valid
);

  localparam int CNT_MAX = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDLE_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  typedef enum logic [1:0] {S_SHOW_HI, S_BLANK_HI, S_SHOW_LO, S_BLANK_LO} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt, last_cnt;
  logic [7:0]         shadow;
  logic               shadow_valid;
  logic [IDLE_W-1:0]  idle;
  logic               load;
  logic [7:0]         disp_byte;
  logic               disp_valid;
  logic [6:0]         seg_nxt;
  logic               dig1_nxt, dig2_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Receive capture and idle timeout; a strobe always beats the timeout
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shadow       <= 8'h00;
      shadow_valid <= 1'b0;
      idle         <= '0;
    end else if (i_RX_DV) begin
      shadow       <= i_RX_Byte;
      shadow_valid <= 1'b1;
      idle         <= '0;
    end else if (TIMEOUT_CLKS > 0) begin
      if (idle == IDLE_W'(TIMEOUT_CLKS - 1)) shadow_valid <= 1'b0;
      else                                   idle         <= idle + IDLE_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= S_BLANK_LO;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count + CNT_W'(1);
    last_cnt  = CNT_W'(BLANK_CLKS - 1);
    if (state == S_SHOW_HI || state == S_SHOW_LO) last_cnt = CNT_W'(CLKS_PER_DIGIT - 1);
    if (count == last_cnt) begin
      count_nxt = '0;
      case (state)
        S_SHOW_HI:  state_nxt = S_BLANK_HI;
        S_BLANK_HI: state_nxt = S_SHOW_LO;
        S_SHOW_LO:  state_nxt = S_BLANK_LO;
        default:    state_nxt = S_SHOW_HI;
      endcase
    end
  end

  // Outputs are decoded from next-state so they change on the same edge as the state;
  // on frame entry the freshly latched byte is what gets decoded.
  always_comb begin
    load       = (state_nxt == S_SHOW_HI) && (state != S_SHOW_HI);
    disp_byte  = load ? shadow : o_Shown_Byte;
    disp_valid = load ? shadow_valid : o_Shown_Valid;
    seg_nxt    = SEG_OFF;
    dig1_nxt   = 1'b1;
    dig2_nxt   = 1'b1;
    case (state_nxt)
      S_SHOW_HI: begin
        if (!disp_valid) begin
          dig1_nxt = 1'b0;
          seg_nxt  = SEG_DASH;
        end else if (!(LZ_BLANK && disp_byte[7:4] == 4'h0)) begin
          dig1_nxt = 1'b0;
          seg_nxt  = glyph(disp_byte[7:4]);
        end
      end
      S_SHOW_LO: begin
        dig2_nxt = 1'b0;
        seg_nxt  = disp_valid ? glyph(disp_byte[3:0]) : SEG_DASH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Seg         <= SEG_OFF;
      o_Dig1        <= 1'b1;
      o_Dig2        <= 1'b1;
      o_Frame_Tick  <= 1'b0;
      o_Shown_Byte  <= 8'h00;
      o_Shown_Valid <= 1'b0;
    end else begin
      o_Seg        <= seg_nxt;
      o_Dig1       <= dig1_nxt;
      o_Dig2       <= dig2_nxt;
      o_Frame_Tick <= load;
      if (load) begin
        o_Shown_Byte  <= shadow;
        o_Shown_Valid <= shadow_valid;
      end
    end
  end

endmodule
